alu_cmd_driver: RTL and testbench

Command sequencer that drives the team's combinational ALU from the initiator side. It accepts register-addressed ALU commands over a valid/ready handshake and reads operands from a small internal register file. It presents the operands and select code to the ALU on registered outputs, waits a programmable settle time, and captures the ALU result and carry. It writes the result back to the register file and reports it on a one-cycle result strobe.

---
 rtl/alu_cmd_driver.sv | 152 +++++++++++++++
 tb/tb_alu_cmd_driver.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_driver.sv
// Sequences register-addressed commands onto a combinational ALU. It presents registered operands,
// waits a programmable settle time, then captures the result, writes it back and strobes it out.
// Latency: accept at edge E, capture at edge E+ALU_WAIT. One command is in flight at a time,
// and cmd_ready is low for the whole of EXEC.
module alu_cmd_driver #(
  parameter int WORDSIZE      = 32,
  parameter int SEL_LINE_SIZE = 4,
  parameter int ALU_WAIT      = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [SEL_LINE_SIZE-1:0] cmd_op,
  input  logic [2:0]               cmd_rd,
  input  logic [2:0]               cmd_rs1,
  input  logic [2:0]               cmd_rs2,
  input  logic                     cmd_imm_en,
  input  logic [WORDSIZE-1:0]      cmd_imm,
  input  logic                     wr_en,
  input  logic [2:0]               wr_addr,
  input  logic [WORDSIZE-1:0]      wr_data,
  input  logic [2:0]               rd_addr,
  output logic [WORDSIZE-1:0]      rd_data,
  output logic [WORDSIZE-1:0]      alu_a,
  output logic [WORDSIZE-1:0]      alu_y,
  output logic [SEL_LINE_SIZE-1:0] alu_sel,
  input  logic [WORDSIZE-1:0]      alu_out,
  input  logic                     alu_carryout,
  output logic                     res_valid,
  output logic [WORDSIZE-1:0]      res_data,
  output logic                     res_carry,
  output logic [2:0]               res_rd,
  output logic                     busy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_t;

  // The counter is loaded with ALU_WAIT-1 so that capture lands exactly ALU_WAIT edges after accept.
  localparam logic [3:0] WAIT_INIT = 4'(ALU_WAIT - 1);

  state_t                     r_state;
  logic [3:0]                 r_cnt;
  logic [2:0]                 r_rd;
  logic                       r_cmd_ready;
  logic                       r_busy;
  logic [WORDSIZE-1:0]        r_alu_a;
  logic [WORDSIZE-1:0]        r_alu_y;
  logic [SEL_LINE_SIZE-1:0]   r_alu_sel;
  logic                       r_res_valid;
  logic [WORDSIZE-1:0]        r_res_data;
  logic                       r_res_carry;
  logic [2:0]                 r_res_rd;
  logic [WORDSIZE-1:0]        r_regs [8];

  logic                       w_accept;
  logic                       w_capture;
  logic [WORDSIZE-1:0]        w_op_a;
  logic [WORDSIZE-1:0]        w_op_y;

  // cmd_ready is a flop, so there is no combinational path from cmd_valid to cmd_ready.
  assign w_accept  = cmd_valid && r_cmd_ready;
  assign w_capture = (r_state == S_EXEC) && (r_cnt == 4'd0);

  // Entry 0 is never written, so it reads as zero without a special case.
  // Operands use pre-edge register contents, so same-edge host writes cannot leak in.
  assign w_op_a  = r_regs[cmd_rs1];
  assign w_op_y  = cmd_imm_en ? cmd_imm : r_regs[cmd_rs2];
  assign rd_data = r_regs[rd_addr];

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign alu_a     = r_alu_a;
  assign alu_y     = r_alu_y;
  assign alu_sel   = r_alu_sel;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_carry = r_res_carry;
  assign res_rd    = r_res_rd;

  // Command FSM: accept and launch operands in IDLE, count the settle time and capture in EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_rd        <= 3'd0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_alu_a     <= '0;
      r_alu_y     <= '0;
      r_alu_sel   <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_carry <= 1'b0;
      r_res_rd    <= 3'd0;
    end else begin
      r_res_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_alu_a     <= w_op_a;
            r_alu_y     <= w_op_y;
            r_alu_sel   <= cmd_op;
            r_rd        <= cmd_rd;
            r_cnt       <= WAIT_INIT;
            r_state     <= S_EXEC;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        S_EXEC: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_res_data  <= alu_out;
            r_res_carry <= alu_carryout;
            r_res_rd    <= r_rd;
            r_res_valid <= 1'b1;
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // Register file: the writeback is assigned last, so it beats a host write to the same entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (wr_en && (wr_addr != 3'd0)) begin
        r_regs[wr_addr] <= wr_data;
      end
      if (w_capture && (r_rd != 3'd0)) begin
        r_regs[r_rd] <= alu_out;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver with two instances (ALU_WAIT=1 and ALU_WAIT=3), each driving its own
// behavioural ALU. A register-file model tracks the expected contents.
module tb_alu_cmd_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cmd_valid;
  logic [1:0]  wr_en;
  logic [3:0]  cmd_op;
  logic [2:0]  cmd_rd, cmd_rs1, cmd_rs2, wr_addr, rd_addr;
  logic        cmd_imm_en;
  logic [31:0] cmd_imm, wr_data;

  logic        cmd_ready [2];
  logic        busy [2];
  logic        res_valid [2];
  logic        res_carry [2];
  logic        alu_carryout [2];
  logic [31:0] rd_data [2];
  logic [31:0] alu_a [2];
  logic [31:0] alu_y [2];
  logic [31:0] alu_out [2];
  logic [31:0] res_data [2];
  logic [3:0]  alu_sel [2];
  logic [2:0]  res_rd [2];

  int          n_total = 0;
  int          n_bad = 0;
  logic [31:0] m_regs [2][8];
  int          wait_of [2] = '{1, 3};

  always #10 clk = ~clk;

  alu_cmd_driver #(.WORDSIZE(32), .SEL_LINE_SIZE(4), .ALU_WAIT(1)) u_dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm), .wr_en(wr_en[0]), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data[0]), .alu_a(alu_a[0]),
    .alu_y(alu_y[0]), .alu_sel(alu_sel[0]), .alu_out(alu_out[0]),
    .alu_carryout(alu_carryout[0]), .res_valid(res_valid[0]), .res_data(res_data[0]),
    .res_carry(res_carry[0]), .res_rd(res_rd[0]), .busy(busy[0])
  );

  alu_cmd_driver #(.WORDSIZE(32), .SEL_LINE_SIZE(4), .ALU_WAIT(3)) u_dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm), .wr_en(wr_en[1]), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data[1]), .alu_a(alu_a[1]),
    .alu_y(alu_y[1]), .alu_sel(alu_sel[1]), .alu_out(alu_out[1]),
    .alu_carryout(alu_carryout[1]), .res_valid(res_valid[1]), .res_data(res_data[1]),
    .res_carry(res_carry[1]), .res_rd(res_rd[1]), .busy(busy[1])
  );

  // Behavioural ALU: returns {carry, result}
  function automatic logic [32:0] alu_fn(logic [3:0] op, logic [31:0] a, logic [31:0] y);
    case (op)
      4'b0000: return {1'b0, a} + {1'b0, y};
      4'b0001: return {1'b0, a} + {1'b0, ~y} + 33'd1;
      4'b1000: return {1'b0, a & y};
      4'b1001: return {1'b0, a | y};
      4'b1010: return {1'b0, a ^ y};
      default: return {1'b0, a};
    endcase
  endfunction

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      {alu_carryout[d], alu_out[d]} = alu_fn(alu_sel[d], alu_a[d], alu_y[d]);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_model();
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 8; a++) m_regs[d][a] = 32'd0;
  endtask

  task automatic check_regs(input int d, input string tag);
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      #1;
      chk(tag, rd_data[d], m_regs[d][a]);
    end
  endtask

  task automatic host_wr(input int d, input logic [2:0] a, input logic [31:0] v);
    wr_en[d] = 1'b1; wr_addr = a; wr_data = v;
    tick();
    wr_en[d] = 1'b0;
    if (a != 3'd0) m_regs[d][a] = v;
  endtask

  // wmode: 0 no host write, 1 host write on the accept edge, 2 host write on the capture edge
  task automatic do_cmd(input int d, input logic [3:0] op, input logic [2:0] rd,
                        input logic [2:0] rs1, input logic [2:0] rs2, input logic imm_en,
                        input logic [31:0] imm, input int wmode, input logic [2:0] wa,
                        input logic [31:0] wv);
    logic [31:0] ea, ey, er;
    logic        ec;
    int          guard;
    ea = m_regs[d][rs1];
    ey = imm_en ? imm : m_regs[d][rs2];
    {ec, er} = alu_fn(op, ea, ey);
    guard = 0;
    while (!cmd_ready[d] && guard < 20) begin
      tick();
      guard++;
    end
    chk("ready_before_cmd", cmd_ready[d], 1);
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm_en = imm_en; cmd_imm = imm;
    cmd_valid[d] = 1'b1;
    if (wmode == 1) begin
      wr_en[d] = 1'b1; wr_addr = wa; wr_data = wv;
    end
    tick();
    cmd_valid[d] = 1'b0;
    wr_en[d] = 1'b0;
    if (wmode == 1 && wa != 3'd0) m_regs[d][wa] = wv;
    chk("alu_a", alu_a[d], ea);
    chk("alu_y", alu_y[d], ey);
    chk("alu_sel", alu_sel[d], op);
    chk("busy_exec", busy[d], 1);
    chk("ready_exec", cmd_ready[d], 0);
    for (int n = 1; n <= wait_of[d]; n++) begin
      if (n == wait_of[d] && wmode == 2) begin
        wr_en[d] = 1'b1; wr_addr = wa; wr_data = wv;
      end
      tick();
      wr_en[d] = 1'b0;
      chk("res_valid_timing", res_valid[d], (n == wait_of[d]));
    end
    chk("res_data", res_data[d], er);
    chk("res_carry", res_carry[d], ec);
    chk("res_rd", res_rd[d], rd);
    chk("busy_done", busy[d], 0);
    chk("ready_done", cmd_ready[d], 1);
    if (wmode == 2 && wa != 3'd0) m_regs[d][wa] = wv;
    if (rd != 3'd0) m_regs[d][rd] = er;
    tick();
    chk("res_valid_pulse", res_valid[d], 0);
    chk("res_data_hold", res_data[d], er);
    check_regs(d, "regfile");
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_ready"}, cmd_ready[d], 1);
      chk({tag, "_busy"}, busy[d], 0);
      chk({tag, "_alu_a"}, alu_a[d], 0);
      chk({tag, "_alu_y"}, alu_y[d], 0);
      chk({tag, "_alu_sel"}, alu_sel[d], 0);
      chk({tag, "_res_valid"}, res_valid[d], 0);
      chk({tag, "_res_data"}, res_data[d], 0);
      chk({tag, "_res_carry"}, res_carry[d], 0);
      chk({tag, "_res_rd"}, res_rd[d], 0);
    end
  endtask

  task automatic back_to_back();
    logic [31:0] ea_b, ey_b, er_a, er_b;
    logic        ec;
    {ec, er_a} = alu_fn(4'b0000, m_regs[1][2], m_regs[1][3]);
    m_regs[1][1] = er_a;
    ea_b = m_regs[1][1];
    ey_b = m_regs[1][2];
    {ec, er_b} = alu_fn(4'b0001, ea_b, ey_b);
    cmd_op = 4'b0000; cmd_rd = 3'd1; cmd_rs1 = 3'd2; cmd_rs2 = 3'd3; cmd_imm_en = 1'b0;
    cmd_valid[1] = 1'b1;
    tick();
    cmd_op = 4'b0001; cmd_rd = 3'd4; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) tick();
      chk("b2b_ready", cmd_ready[1], (k == 3 || k >= 7));
      chk("b2b_res_valid", res_valid[1], (k == 3 || k == 7));
      if (k == 3) chk("b2b_res_a", res_data[1], er_a);
      if (k == 4) begin
        chk("b2b_alu_a", alu_a[1], ea_b);
        chk("b2b_alu_y", alu_y[1], ey_b);
        cmd_valid[1] = 1'b0;
      end
      if (k == 7) chk("b2b_res_b", res_data[1], er_b);
    end
    m_regs[1][4] = er_b;
    check_regs(1, "b2b_regs");
  endtask

  initial begin
    logic [3:0] ops [5] = '{4'b0000, 4'b0001, 4'b1000, 4'b1001, 4'b1010};
    rst = 1'b1;
    cmd_valid = 2'b00; wr_en = 2'b00;
    cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm_en = 1'b0; cmd_imm = '0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    zero_model();
    tick(); tick();
    check_reset_outputs("rst0");
    check_regs(0, "rst0_regs");
    check_regs(1, "rst0_regs");
    rst = 1'b0;
    tick();

    // add
    host_wr(0, 3'd1, 32'd5);
    host_wr(0, 3'd2, 32'd3);
    do_cmd(0, 4'b0000, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0, 0, 3'd0, 32'd0);
    // carry and subtract
    host_wr(0, 3'd1, 32'hFFFF_FFFF);
    host_wr(0, 3'd2, 32'd1);
    do_cmd(0, 4'b0000, 3'd4, 3'd1, 3'd2, 1'b0, 32'd0, 0, 3'd0, 32'd0);
    do_cmd(0, 4'b0001, 3'd5, 3'd2, 3'd1, 1'b0, 32'd0, 0, 3'd0, 32'd0);
    chk("sub_r5", m_regs[0][5], 32'd2);
    // immediate into r0, then r0 operands
    do_cmd(0, 4'b1000, 3'd0, 3'd1, 3'd0, 1'b1, 32'h0F0F, 0, 3'd0, 32'd0);
    do_cmd(0, 4'b0000, 3'd6, 3'd0, 3'd0, 1'b0, 32'd0, 0, 3'd0, 32'd0);
    // writeback beats host write to the same register
    do_cmd(0, 4'b1000, 3'd6, 3'd1, 3'd0, 1'b1, 32'h99, 2, 3'd6, 32'h1234);
    // host write to rs1 on the accept edge does not affect the operand
    do_cmd(0, 4'b0000, 3'd7, 3'd2, 3'd2, 1'b0, 32'd0, 1, 3'd2, 32'hABCD);

    // back-to-back on the ALU_WAIT=3 instance
    host_wr(1, 3'd2, 32'h1000_0000);
    host_wr(1, 3'd3, 32'h0000_0234);
    back_to_back();

    // randomized commands with random host-write collisions
    for (int i = 0; i < 40; i++) begin
      int d;
      d = int'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) host_wr(d, 3'($urandom_range(0, 7)), $urandom);
      do_cmd(d, ops[$urandom_range(0, 4)], 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
             int'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), $urandom);
    end

    // reset during EXEC abandons the command
    host_wr(1, 3'd7, 32'h55);
    cmd_op = 4'b0000; cmd_rd = 3'd7; cmd_rs1 = 3'd7; cmd_rs2 = 3'd7; cmd_imm_en = 1'b0;
    cmd_valid[1] = 1'b1;
    tick();
    cmd_valid[1] = 1'b0;
    chk("exec_busy", busy[1], 1);
    tick();
    #2 rst = 1'b1;
    #1;
    zero_model();
    check_reset_outputs("rst_exec");
    check_regs(1, "rst_exec_regs");
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rst_exec_no_valid", res_valid[1], 0);
    end
    check_regs(1, "rst_exec_regs2");

    // mid-cycle reset after activity on the ALU_WAIT=1 instance
    host_wr(0, 3'd2, 32'h77);
    do_cmd(0, 4'b1001, 3'd3, 3'd2, 3'd2, 1'b1, 32'h100, 0, 3'd0, 32'd0);
    #3 rst = 1'b1;
    #1;
    zero_model();
    check_reset_outputs("rst_mid");
    check_regs(0, "rst_mid_regs");
    tick();
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
